// File: rtl/tff_toggle_gen.sv
// -----------------------------------------------------------------------------
// tff_toggle_gen
// Toggle-request generator for the toggle flip-flop stage. A raw push-button
// is synchronized and debounced, and each clean press yields one single-cycle
// pulse on t. In auto mode a programmable prescaler also emits a pulse every
// div+1 cycles. Coincident press and auto events merge into one pulse.
//
// Ports:
//   clk        rising-edge clock for all state
//   reset      asynchronous, active-high; clears all state immediately
//   btn_in     raw, asynchronous, bouncing button level
//   auto_en    synchronous enable for periodic pulses
//   div        auto period minus one (period is div+1 cycles)
//   t          registered toggle request, one cycle wide per event
//   btn_level  registered debounced button level
// -----------------------------------------------------------------------------
module tff_toggle_gen #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DIV_WIDTH       = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 btn_in,
  input  logic                 auto_en,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 t,
  output logic                 btn_level
);

  // Counter only ever needs to reach DEBOUNCE_CYCLES-1.
  localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [DIV_WIDTH-1:0] PRE_ONE = DIV_WIDTH'(1);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_HIGH = 2'd1;
  localparam logic [1:0] ST_PRESSED   = 2'd2;
  localparam logic [1:0] ST_WAIT_LOW  = 2'd3;

  logic                 sync1_r;
  logic                 sync2_r;
  logic [1:0]           state_r;
  logic [1:0]           state_s;
  logic [CNT_W-1:0]     cnt_r;
  logic [CNT_W-1:0]     cnt_s;
  logic                 press_s;
  logic                 level_s;
  logic [DIV_WIDTH-1:0] pre_r;
  logic [DIV_WIDTH-1:0] pre_s;
  logic                 auto_s;
  logic                 t_r;
  logic                 btn_level_r;

  // Two-flop synchronizer for the asynchronous button input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= btn_in;
      sync2_r <= sync1_r;
    end
  end

  // Debounce next-state logic; a level change must hold for DEBOUNCE_CYCLES
  // consecutive synchronized samples, any glitch restarts qualification.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    press_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (sync2_r) begin
          state_s = ST_WAIT_HIGH;
          cnt_s   = CNT_ONE;
        end else begin
          state_s = ST_IDLE;
          cnt_s   = '0;
        end
      end
      ST_WAIT_HIGH: begin
        if (!sync2_r) begin
          state_s = ST_IDLE;
          cnt_s   = '0;
        end else if (cnt_r == CNT_MAX) begin
          state_s = ST_PRESSED;
          cnt_s   = '0;
          press_s = 1'b1;
        end else begin
          state_s = ST_WAIT_HIGH;
          cnt_s   = cnt_r + CNT_ONE;
        end
      end
      ST_PRESSED: begin
        if (!sync2_r) begin
          state_s = ST_WAIT_LOW;
          cnt_s   = CNT_ONE;
        end else begin
          state_s = ST_PRESSED;
          cnt_s   = '0;
        end
      end
      ST_WAIT_LOW: begin
        // Release qualification never generates a pulse.
        if (sync2_r) begin
          state_s = ST_PRESSED;
          cnt_s   = '0;
        end else if (cnt_r == CNT_MAX) begin
          state_s = ST_IDLE;
          cnt_s   = '0;
        end else begin
          state_s = ST_WAIT_LOW;
          cnt_s   = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = '0;
      end
    endcase
  end

  // Debounced level follows the next state so it is registered with it.
  always_comb begin
    if ((state_s == ST_PRESSED) || (state_s == ST_WAIT_LOW)) begin
      level_s = 1'b1;
    end else begin
      level_s = 1'b0;
    end
  end

  // Prescaler next-state; >= lets a div lowered below pre wrap immediately.
  always_comb begin
    if (!auto_en) begin
      pre_s  = '0;
      auto_s = 1'b0;
    end else if (pre_r >= div) begin
      pre_s  = '0;
      auto_s = 1'b1;
    end else begin
      pre_s  = pre_r + PRE_ONE;
      auto_s = 1'b0;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      pre_r       <= '0;
      t_r         <= 1'b0;
      btn_level_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      pre_r       <= pre_s;
      t_r         <= press_s | auto_s;
      btn_level_r <= level_s;
    end
  end

  assign t         = t_r;
  assign btn_level = btn_level_r;

endmodule

// File: tb/tb_tff_toggle_gen.sv
// -----------------------------------------------------------------------------
// tb_tff_toggle_gen
// Directed self-checking bench for tff_toggle_gen (DEBOUNCE_CYCLES=4,
// DIV_WIDTH=8). Edges are numbered from the first edge that samples a new
// input value; outputs are observed 1 time unit after each rising edge.
// A behavioural toggle flip-flop driven from t models the downstream stage.
// -----------------------------------------------------------------------------
module tb_tff_toggle_gen;

  logic       clk;
  logic       reset;
  logic       btn_in;
  logic       auto_en;
  logic [7:0] div;
  logic       t;
  logic       btn_level;

  logic       q_r;
  logic       qbar;

  int n_checks;
  int n_fail;

  tff_toggle_gen #(
    .DEBOUNCE_CYCLES(4),
    .DIV_WIDTH(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_in(btn_in),
    .auto_en(auto_en),
    .div(div),
    .t(t),
    .btn_level(btn_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream toggle flip-flop on the same clock and reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_r <= 1'b0;
    end else if (t) begin
      q_r <= ~q_r;
    end else begin
      q_r <= q_r;
    end
  end
  assign qbar = ~q_r;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks = n_checks + 1;
    if (act !== exp_v) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp_v, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [6:0] bounce_pat;

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    bounce_pat = 7'b1011011; // bit i is the value driven at step i: 1,1,0,1,1,0,1
    reset      = 1'b1;
    btn_in     = 1'b1;
    auto_en    = 1'b1;
    div        = 8'd0;

    // Reset holds everything low even with the button held and div=0 auto.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("rst_t", {31'd0, t}, 32'd0);
      check_val("rst_lvl", {31'd0, btn_level}, 32'd0);
    end
    auto_en = 1'b0;
    tick();
    reset = 1'b0;

    // Held button is qualified after reset release: pulse at edge 6.
    for (int e = 1; e <= 7; e++) begin
      tick();
      check_val("rel_t", {31'd0, t}, {31'd0, (e == 6)});
      check_val("rel_lvl", {31'd0, btn_level}, {31'd0, (e >= 6)});
    end

    // Clean release: level falls at edge 6, no pulse.
    btn_in = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check_val("up_t", {31'd0, t}, 32'd0);
      check_val("up_lvl", {31'd0, btn_level}, {31'd0, (e < 6)});
    end

    // Clean press held 20 cycles, then release.
    btn_in = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      check_val("press_t", {31'd0, t}, {31'd0, (e == 6)});
      check_val("press_lvl", {31'd0, btn_level}, {31'd0, (e >= 6)});
    end
    btn_in = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check_val("unpress_t", {31'd0, t}, 32'd0);
      check_val("unpress_lvl", {31'd0, btn_level}, {31'd0, (e < 6)});
    end

    // Bounce: longest run of ones is 3 samples, never qualifies.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 7; i++) begin
        btn_in = bounce_pat[i];
        tick();
        if (!((r == 2) && (i == 6))) begin
          check_val("bounce_t", {31'd0, t}, 32'd0);
          check_val("bounce_lvl", {31'd0, btn_level}, 32'd0);
        end
      end
    end
    // Last pattern sample was the final stable rise (its edge was edge 1).
    for (int e = 2; e <= 8; e++) begin
      tick();
      check_val("settle_t", {31'd0, t}, {31'd0, (e == 6)});
      check_val("settle_lvl", {31'd0, btn_level}, {31'd0, (e >= 6)});
    end
    btn_in = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check_val("settle_rel", {31'd0, btn_level}, {31'd0, (e < 6)});
    end

    // Auto mode div=3: pulses after edges 4, 8, 12.
    div     = 8'd3;
    auto_en = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      tick();
      check_val("auto3_t", {31'd0, t}, {31'd0, ((e % 4) == 0)});
    end
    // pre=2 now; div=1 drops below it and must wrap next edge, then period 2.
    div = 8'd1;
    for (int e = 15; e <= 20; e++) begin
      tick();
      check_val("auto1_t", {31'd0, t}, {31'd0, ((e % 2) == 1)});
    end
    // div=0: continuous pulses.
    div = 8'd0;
    for (int e = 21; e <= 24; e++) begin
      tick();
      check_val("auto0_t", {31'd0, t}, 32'd1);
    end
    // Clearing auto_en: the registered pulse ends on the next edge.
    auto_en = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      tick();
      check_val("autooff_t", {31'd0, t}, 32'd0);
    end

    // Coincidence: press edge 6 lines up with auto edge 8 (div=7).
    div     = 8'd7;
    auto_en = 1'b1;
    for (int e = 1; e <= 17; e++) begin
      tick();
      if (e == 2) begin
        btn_in = 1'b1;
      end
      check_val("coin_t", {31'd0, t}, {31'd0, ((e == 8) || (e == 16))});
      check_val("coin_lvl", {31'd0, btn_level}, {31'd0, (e >= 8)});
    end
    auto_en = 1'b0;
    btn_in  = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
    end
    check_val("coin_rel_lvl", {31'd0, btn_level}, 32'd0);

    // Reset while t=1 clears outputs immediately, then a held button re-qualifies.
    btn_in = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
    end
    check_val("pre_rst_t", {31'd0, t}, 32'd1);
    reset = 1'b1;
    #1;
    check_val("async_t", {31'd0, t}, 32'd0);
    check_val("async_lvl", {31'd0, btn_level}, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check_val("requal_t", {31'd0, t}, {31'd0, (e == 6)});
    end

    // Integration with the toggle flip-flop: three presses give q 1,0,1.
    btn_in = 1'b0;
    reset  = 1'b1;
    tick();
    reset = 1'b0;
    check_val("tff_q0", {31'd0, q_r}, 32'd0);
    for (int p = 0; p < 3; p++) begin
      btn_in = 1'b1;
      for (int e = 1; e <= 10; e++) begin
        tick();
      end
      btn_in = 1'b0;
      for (int e = 1; e <= 10; e++) begin
        tick();
      end
      check_val("tff_q", {31'd0, q_r}, {31'd0, (p != 1)});
      check_val("tff_qbar", {31'd0, qbar}, {31'd0, (p == 1)});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
